alu_operand_stage: RTL and testbench

- ID/EX stage directly upstream of the ALU.
- Accepts a fetched 32-bit MIPS instruction plus register-file read data.
- Decodes the 4-bit ALU operation code and selects/extends operands, applying EX/MEM and MEM/WB forwarding.
- Registers everything into a single valid/ready pipeline slot whose outputs drive the ALU inputs T1, T2, shamt and ALUOp.

---
 rtl/alu_operand_stage.sv | 272 +++++++++++++++++++++++++++
 tb/tb_alu_operand_stage.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// Purpose : ID/EX stage ahead of the ALU; decodes a MIPS word into ALUOp/operands with EX/MEM and MEM/WB forwarding.
// Latency : 1 cycle from accept (in_valid & in_ready) to out_valid.
// Backpr. : single slot; in_ready = !out_valid | out_ready, so a held slot stalls the producer with outputs frozen.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready        upstream handshake; instr, rs_data, rt_data sampled on accept
//   exm_wr/exm_rd/exm_data   EX/MEM writeback bus (forwarding source, higher priority)
//   mwb_wr/mwb_rd/mwb_data   MEM/WB writeback bus (forwarding source)
//   flush                    kills slot contents and any same-cycle accept
//   out_valid/out_ready      downstream handshake toward the ALU
//   T1, T2, shamt, ALUOp     ALU inputs
//   dest, reg_write, mem_read, mem_write, br_eq, br_ne, illegal   control flags
//   ill_count                saturating count of accepted illegal instructions
module alu_operand_stage #(
    parameter bit FWD_EN    = 1'b1,
    parameter int ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          instr,
    input  logic [31:0]          rs_data,
    input  logic [31:0]          rt_data,
    input  logic                 exm_wr,
    input  logic [4:0]           exm_rd,
    input  logic [31:0]          exm_data,
    input  logic                 mwb_wr,
    input  logic [4:0]           mwb_rd,
    input  logic [31:0]          mwb_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          T1,
    output logic [31:0]          T2,
    output logic [4:0]           shamt,
    output logic [3:0]           ALUOp,
    output logic [4:0]           dest,
    output logic                 reg_write,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 br_eq,
    output logic                 br_ne,
    output logic                 illegal,
    output logic [ILL_CNT_W-1:0] ill_count
);

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_NOR = 4'b0011,
        ALU_SLL = 4'b0100,
        ALU_SRL = 4'b0101,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_LUI = 4'b1000
    } alu_op_t;

    // Everything the ALU side sees, held as one registered bundle.
    typedef struct packed {
        logic [31:0] t1;
        logic [31:0] t2;
        logic [4:0]  shamt;
        alu_op_t     op;
        logic [4:0]  dest;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        br_eq;
        logic        br_ne;
        logic        illegal;
    } slot_t;

    // Field extraction
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs_idx;
    logic [4:0]  rt_idx;
    logic [4:0]  rd_idx;
    logic [15:0] imm;
    logic [31:0] imm_sx;
    logic [31:0] imm_zx;

    assign opcode = instr[31:26];
    assign rs_idx = instr[25:21];
    assign rt_idx = instr[20:16];
    assign rd_idx = instr[15:11];
    assign funct  = instr[5:0];
    assign imm    = instr[15:0];
    assign imm_sx = {{16{imm[15]}}, imm};
    assign imm_zx = {16'h0000, imm};

    // Forwarding: $0 reads as zero, EX/MEM is younger than MEM/WB so it wins.
    function automatic logic [31:0] fwd_sel(
        input logic [4:0]  src,
        input logic [31:0] rf_val,
        input logic        ex_wr,
        input logic [4:0]  ex_rd,
        input logic [31:0] ex_val,
        input logic        wb_wr,
        input logic [4:0]  wb_rd,
        input logic [31:0] wb_val
    );
        logic [31:0] res;
        res = rf_val;
        if (FWD_EN) begin
            if (src == 5'd0) begin
                res = 32'd0;
            end else if (ex_wr && (ex_rd == src)) begin
                res = ex_val;
            end else if (wb_wr && (wb_rd == src)) begin
                res = wb_val;
            end
        end
        return res;
    endfunction

    logic [31:0] rs_fwd;
    logic [31:0] rt_fwd;

    always_comb begin
        rs_fwd = fwd_sel(rs_idx, rs_data, exm_wr, exm_rd, exm_data, mwb_wr, mwb_rd, mwb_data);
        rt_fwd = fwd_sel(rt_idx, rt_data, exm_wr, exm_rd, exm_data, mwb_wr, mwb_rd, mwb_data);
    end

    // Decode
    slot_t dec;
    logic  bad_op;

    always_comb begin
        dec    = '0;
        bad_op = 1'b0;
        case (opcode)
            6'h00: begin
                dec.t1        = rs_fwd;
                dec.t2        = rt_fwd;
                dec.dest      = rd_idx;
                dec.reg_write = 1'b1;
                case (funct)
                    6'h24:        dec.op = ALU_AND;
                    6'h25:        dec.op = ALU_OR;
                    6'h20, 6'h21: dec.op = ALU_ADD;
                    6'h27:        dec.op = ALU_NOR;
                    6'h00: begin
                        dec.op    = ALU_SLL;
                        dec.shamt = instr[10:6];
                    end
                    6'h02: begin
                        dec.op    = ALU_SRL;
                        dec.shamt = instr[10:6];
                    end
                    6'h22, 6'h23: dec.op = ALU_SUB;
                    6'h2A:        dec.op = ALU_SLT;
                    default:      bad_op = 1'b1;
                endcase
            end
            6'h08, 6'h09: begin
                dec.t1        = rs_fwd;
                dec.t2        = imm_sx;
                dec.op        = ALU_ADD;
                dec.dest      = rt_idx;
                dec.reg_write = 1'b1;
            end
            6'h0C: begin
                dec.t1        = rs_fwd;
                dec.t2        = imm_zx;
                dec.op        = ALU_AND;
                dec.dest      = rt_idx;
                dec.reg_write = 1'b1;
            end
            6'h0D: begin
                dec.t1        = rs_fwd;
                dec.t2        = imm_zx;
                dec.op        = ALU_OR;
                dec.dest      = rt_idx;
                dec.reg_write = 1'b1;
            end
            6'h0A: begin
                dec.t1        = rs_fwd;
                dec.t2        = imm_sx;
                dec.op        = ALU_SLT;
                dec.dest      = rt_idx;
                dec.reg_write = 1'b1;
            end
            6'h0F: begin
                // The ALU performs the upper-half placement; T2 carries the raw immediate.
                dec.t1        = rs_fwd;
                dec.t2        = imm_zx;
                dec.op        = ALU_LUI;
                dec.dest      = rt_idx;
                dec.reg_write = 1'b1;
            end
            6'h23: begin
                dec.t1        = rs_fwd;
                dec.t2        = imm_sx;
                dec.op        = ALU_ADD;
                dec.dest      = rt_idx;
                dec.reg_write = 1'b1;
                dec.mem_read  = 1'b1;
            end
            6'h2B: begin
                dec.t1        = rs_fwd;
                dec.t2        = imm_sx;
                dec.op        = ALU_ADD;
                dec.mem_write = 1'b1;
            end
            6'h04, 6'h05: begin
                // Branch compare: rt is a register source, so it is forwarded.
                dec.t1    = rs_fwd;
                dec.t2    = rt_fwd;
                dec.op    = ALU_SUB;
                dec.br_eq = (opcode == 6'h04);
                dec.br_ne = (opcode == 6'h05);
            end
            default: bad_op = 1'b1;
        endcase

        // Illegal words carry no operands or side effects into EX.
        if (bad_op) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end

        // Writes to $0 are architecturally discarded.
        if (dec.dest == 5'd0) begin
            dec.reg_write = 1'b0;
        end
    end

    // Pipeline slot
    slot_t slot;
    logic  accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            slot      <= '0;
            ill_count <= '0;
        end else begin
            if (flush) begin
                // Same-cycle accept is dropped entirely, including its count.
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
                slot      <= dec;
                if (dec.illegal && (ill_count != {ILL_CNT_W{1'b1}})) begin
                    ill_count <= ill_count + ILL_CNT_W'(1);
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign T1        = slot.t1;
    assign T2        = slot.t2;
    assign shamt     = slot.shamt;
    assign ALUOp     = slot.op;
    assign dest      = slot.dest;
    assign reg_write = slot.reg_write;
    assign mem_read  = slot.mem_read;
    assign mem_write = slot.mem_write;
    assign br_eq     = slot.br_eq;
    assign br_ne     = slot.br_ne;
    assign illegal   = slot.illegal;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Purpose : randomized + directed bench for alu_operand_stage against a table-driven reference model.
// Latency : model predicts slot contents one edge after accept.
// Backpr. : model tracks the single slot, in_ready and flush/drain rules.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic        exm_wr = 1'b0;
    logic [4:0]  exm_rd = '0;
    logic [31:0] exm_data = '0;
    logic        mwb_wr = 1'b0;
    logic [4:0]  mwb_rd = '0;
    logic [31:0] mwb_data = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] T1;
    logic [31:0] T2;
    logic [4:0]  shamt;
    logic [3:0]  ALUOp;
    logic [4:0]  dest;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        br_eq;
    logic        br_ne;
    logic        illegal;
    logic [7:0]  ill_count;

    alu_operand_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
        .exm_wr(exm_wr), .exm_rd(exm_rd), .exm_data(exm_data),
        .mwb_wr(mwb_wr), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .T1(T1), .T2(T2), .shamt(shamt), .ALUOp(ALUOp), .dest(dest),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .br_eq(br_eq), .br_ne(br_ne), .illegal(illegal),
        .ill_count(ill_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: opcode/funct lookup tables plus architectural rules.
    typedef struct packed {
        logic [31:0] t1;
        logic [31:0] t2;
        logic [4:0]  sh;
        logic [3:0]  op;
        logic [4:0]  dest;
        logic [5:0]  flags;  // {reg_write, mem_read, mem_write, br_eq, br_ne, illegal}
    } exp_t;

    logic [3:0] r_tab [int];
    logic [3:0] i_tab [int];
    int r_list [10] = '{'h24, 'h25, 'h20, 'h21, 'h27, 'h00, 'h02, 'h22, 'h23, 'h2A};
    int i_list [10] = '{'h08, 'h09, 'h0C, 'h0D, 'h0A, 'h0F, 'h23, 'h2B, 'h04, 'h05};

    function automatic logic [31:0] src_val(input logic [4:0] s, input logic [31:0] rf);
        if (s == 0) return 32'd0;
        if (exm_wr && exm_rd == s) return exm_data;
        if (mwb_wr && mwb_rd == s) return mwb_data;
        return rf;
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] w);
        exp_t e;
        int op, fn;
        logic rw, mr, mw, be, bn, il;
        logic signed [15:0] imm16;
        logic signed [31:0] simm;
        e = '0;
        rw = 0; mr = 0; mw = 0; be = 0; bn = 0; il = 0;
        op = int'(w[31:26]);
        fn = int'(w[5:0]);
        imm16 = w[15:0];
        simm = imm16;
        if (op == 0) begin
            if (!r_tab.exists(fn)) begin
                il = 1;
            end else begin
                e.op = r_tab[fn];
                e.t1 = src_val(w[25:21], rs_data);
                e.t2 = src_val(w[20:16], rt_data);
                e.dest = w[15:11];
                rw = 1;
                if (fn == 'h00 || fn == 'h02) e.sh = w[10:6];
            end
        end else if (!i_tab.exists(op)) begin
            il = 1;
        end else begin
            e.op = i_tab[op];
            e.t1 = src_val(w[25:21], rs_data);
            e.dest = w[20:16];
            rw = 1;
            e.t2 = simm;
            if (op == 'h0C || op == 'h0D || op == 'h0F) e.t2 = 32'(w[15:0]);
            if (op == 'h23) mr = 1;
            if (op == 'h2B) begin mw = 1; rw = 0; e.dest = 0; end
            if (op == 'h04 || op == 'h05) begin
                e.t2 = src_val(w[20:16], rt_data);
                rw = 0; e.dest = 0;
                be = (op == 'h04);
                bn = (op == 'h05);
            end
        end
        if (e.dest == 0) rw = 0;
        e.flags = {rw, mr, mw, be, bn, il};
        return e;
    endfunction

    // Slot model
    logic       m_valid = 0;
    exp_t       m_slot = '0;
    int         m_cnt = 0;

    task automatic model_reset();
        m_valid = 0;
        m_slot = '0;
        m_cnt = 0;
    endtask

    task automatic compare_outputs();
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("ill_count", 32'(ill_count), 32'(m_cnt));
        if (m_valid) begin
            check("T1", T1, m_slot.t1);
            check("T2", T2, m_slot.t2);
            check("shamt", 32'(shamt), 32'(m_slot.sh));
            check("ALUOp", 32'(ALUOp), 32'(m_slot.op));
            check("dest", 32'(dest), 32'(m_slot.dest));
            check("flags", 32'({reg_write, mem_read, mem_write, br_eq, br_ne, illegal}), 32'(m_slot.flags));
        end
    endtask

    // One clock: inputs already driven after the falling edge.
    task automatic step();
        exp_t nx;
        #1;
        check("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
        nx = ref_decode(instr);
        @(posedge clk);
        if (flush) begin
            m_valid = 0;
        end else if (in_valid && (!m_valid || out_ready)) begin
            m_valid = 1;
            m_slot = nx;
            if (nx.flags[0] && m_cnt < 255) m_cnt++;
        end else if (out_ready) begin
            m_valid = 0;
        end
        #1;
        compare_outputs();
        @(negedge clk);
    endtask

    task automatic quiet_buses();
        exm_wr = 0; exm_rd = 0; exm_data = 0;
        mwb_wr = 0; mwb_rd = 0; mwb_data = 0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] w;
        int k;
        k = $urandom_range(0, 9);
        fn = 6'($urandom);
        if (k < 4) begin
            op = 6'h00;
            fn = 6'(r_list[$urandom_range(0, 9)]);
        end else if (k < 8) begin
            op = 6'(i_list[$urandom_range(0, 9)]);
        end else if (k == 8) begin
            op = 6'h00;
            fn = 6'h3F;
        end else begin
            op = 6'h3F;
        end
        w = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 5'($urandom), fn};
        if (op != 6'h00) w[15:0] = 16'($urandom);
        return w;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        r_tab['h24] = 4'd0; r_tab['h25] = 4'd1; r_tab['h20] = 4'd2; r_tab['h21] = 4'd2;
        r_tab['h27] = 4'd3; r_tab['h00] = 4'd4; r_tab['h02] = 4'd5; r_tab['h22] = 4'd6;
        r_tab['h23] = 4'd6; r_tab['h2A] = 4'd7;
        i_tab['h08] = 4'd2; i_tab['h09] = 4'd2; i_tab['h0C] = 4'd0; i_tab['h0D] = 4'd1;
        i_tab['h0A] = 4'd7; i_tab['h0F] = 4'd8; i_tab['h23] = 4'd2; i_tab['h2B] = 4'd2;
        i_tab['h04] = 4'd6; i_tab['h05] = 4'd6;

        // Async reset asserted before any clock edge.
        #2 rst = 0;
        #1;
        model_reset();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_ill_count", 32'(ill_count), 32'd0);
        check("rst_T1", T1, 32'd0);
        check("rst_T2", T2, 32'd0);
        check("rst_ctrl", 32'({ALUOp, dest, shamt, reg_write, mem_read, mem_write, br_eq, br_ne, illegal}), 32'd0);
        @(negedge clk);
        rst = 1;

        // add $3,$1,$2
        out_ready = 1; in_valid = 1;
        instr = 32'h00221820; rs_data = 5; rt_data = 7;
        step();
        check("add_T1", T1, 32'd5);
        check("add_T2", T2, 32'd7);
        check("add_op", 32'(ALUOp), 32'b0010);
        check("add_dest", 32'(dest), 32'd3);
        check("add_rw", 32'({out_valid, reg_write}), 32'b11);

        // addi $2,$1,-1 then lui $4,0x1234
        instr = 32'h2022FFFF; rs_data = 10;
        step();
        check("addi_T2", T2, 32'hFFFFFFFF);
        check("addi_dest", 32'(dest), 32'd2);
        instr = 32'h3C041234;
        step();
        check("lui_op", 32'(ALUOp), 32'b1000);
        check("lui_T2", T2, 32'h00001234);

        // Forwarding: EX/MEM beats MEM/WB; $0 never forwarded.
        instr = 32'h00A03020; rs_data = 32'h11;
        exm_wr = 1; exm_rd = 5; exm_data = 32'hAA;
        mwb_wr = 1; mwb_rd = 5; mwb_data = 32'hBB;
        step();
        check("fwd_exm_T1", T1, 32'hAA);
        instr = 32'h00003020; exm_rd = 0; mwb_rd = 0;
        step();
        check("fwd_zero_T1", T1, 32'd0);
        quiet_buses();

        // Stall: slot held for 3 cycles, next instruction waits.
        instr = 32'h00221820; rs_data = 32'h1234; rt_data = 32'h5678;
        step();
        out_ready = 0;
        instr = 32'h00432024;
        for (int i = 0; i < 3; i++) begin
            exm_wr = 1; exm_rd = 1; exm_data = $urandom;
            step();
            check("stall_T1", T1, 32'h1234);
        end
        out_ready = 1;
        step();
        check("resume_op", 32'(ALUOp), 32'b0000);
        in_valid = 0;
        step();
        quiet_buses();

        // Flush beats a same-cycle accept, including the illegal count.
        in_valid = 1; instr = 32'hFC000000; flush = 1;
        step();
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_cnt", 32'(ill_count), 32'd0);
        flush = 0;
        step();
        check("ill_one", 32'(ill_count), 32'd1);

        // Async reset mid-stream.
        #2 rst = 0;
        #1;
        model_reset();
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_cnt", 32'(ill_count), 32'd0);
        @(negedge clk);
        rst = 1;

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 19) == 0);
            instr = rand_instr();
            rs_data = $urandom; rt_data = $urandom;
            exm_wr = $urandom_range(0, 1); exm_rd = 5'($urandom_range(0, 7)); exm_data = $urandom;
            mwb_wr = $urandom_range(0, 1); mwb_rd = 5'($urandom_range(0, 7)); mwb_data = $urandom;
            step();
        end

        // Saturation: 300 illegal accepts from a fresh count.
        flush = 0;
        rst = 0;
        #1;
        model_reset();
        @(negedge clk);
        rst = 1;
        quiet_buses();
        in_valid = 1; out_ready = 1; instr = 32'hFC000000;
        for (int i = 0; i < 300; i++) begin
            step();
        end
        check("sat_cnt", 32'(ill_count), 32'd255);
        check("sat_illegal", 32'(illegal), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
